// File: rtl/ins_decode_stage.sv
// ins_decode_stage
//
// Registered RV32I decode stage sitting between fetch and execute. The
// combinational decoder turns the incoming instruction word into execute,
// memory and write-back control fields, and a one-entry valid/ready output
// register holds the decoded bundle until execute takes it. A held load whose
// destination is read by the incoming instruction stalls the input for one
// cycle, so execute sees a bubble between the load and its consumer.
//
// Optional feature macro: DECODE_IMM_GEN_EN
//   defined     -> IMMEDIATE carries the sign-extended, format-correct value
//   not defined -> IMMEDIATE is tied to 0 and execute rebuilds it from
//                  IMM_FORMAT; no immediate logic is built
//
// Ports:
//   CLK, RESET_N            clock, synchronous active-low reset
//   FLUSH                   drop the held bundle and refuse the incoming one
//   IN_VALID / IN_READY     handshake with fetch (INSTRUCTION, PC)
//   OUT_VALID / OUT_READY   handshake with execute
//   OUT_PC                  PC of the held instruction
//   IMM_FORMAT              R=0, I=1, S=2, U=3, SB=4, UJ=5
//   IMMEDIATE               see macro above
//   RS1/RS2/RD_ADDRESS      register indices, 0 where the format has none
//   SHIFT_AMOUNT            shamt for SLLI/SRLI/SRAI, else 0
//   ALU_INSTRUCTION         ALU operation code
//   ALU_INPUT_1_SELECT      0=rs1, 1=PC
//   ALU_INPUT_2_SELECT      0=rs2, 1=immediate
//   DATA_CACHE_READ/WRITE   load/store size codes, 0 = no access
//   WRITE_BACK_MUX_SELECT   0=ALU, 1=data cache
//   RD_WRITE_ENABLE         write rd (never for x0)
//   ILLEGAL_INSTRUCTION     held bundle is an illegal encoding

module ins_decode_stage #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [31:0]              INSTRUCTION,
  input  logic [ADDRESS_WIDTH-1:0] PC,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [ADDRESS_WIDTH-1:0] OUT_PC,
  output logic [2:0]               IMM_FORMAT,
  output logic [31:0]              IMMEDIATE,
  output logic [4:0]               RS1_ADDRESS,
  output logic [4:0]               RS2_ADDRESS,
  output logic [4:0]               RD_ADDRESS,
  output logic [4:0]               SHIFT_AMOUNT,
  output logic [4:0]               ALU_INSTRUCTION,
  output logic                     ALU_INPUT_1_SELECT,
  output logic                     ALU_INPUT_2_SELECT,
  output logic [2:0]               DATA_CACHE_READ,
  output logic [1:0]               DATA_CACHE_WRITE,
  output logic                     WRITE_BACK_MUX_SELECT,
  output logic                     RD_WRITE_ENABLE,
  output logic                     ILLEGAL_INSTRUCTION
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_U  = 3'd3;
  localparam logic [2:0] FMT_SB = 3'd4;
  localparam logic [2:0] FMT_UJ = 3'd5;

  localparam logic [4:0] ALU_NONE     = 5'd0;
  localparam logic [4:0] ALU_ADD      = 5'd1;
  localparam logic [4:0] ALU_SUB      = 5'd2;
  localparam logic [4:0] ALU_SLL      = 5'd3;
  localparam logic [4:0] ALU_SLT      = 5'd4;
  localparam logic [4:0] ALU_SLTU     = 5'd5;
  localparam logic [4:0] ALU_XOR      = 5'd6;
  localparam logic [4:0] ALU_SRL      = 5'd7;
  localparam logic [4:0] ALU_SRA      = 5'd8;
  localparam logic [4:0] ALU_OR       = 5'd9;
  localparam logic [4:0] ALU_AND      = 5'd10;
  localparam logic [4:0] ALU_PASS_B   = 5'd11;
  localparam logic [4:0] ALU_PC_PLUS4 = 5'd12;

  logic [6:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;

  assign opcode = INSTRUCTION[6:0];
  assign fun3   = INSTRUCTION[14:12];
  assign fun7   = INSTRUCTION[31:25];

  // Raw per-opcode decode, before the illegal-encoding override.
  logic [2:0] raw_fmt;
  logic [4:0] raw_alu;
  logic       raw_in1;
  logic       raw_in2;
  logic [2:0] raw_dc_read;
  logic [1:0] raw_dc_write;
  logic       raw_wb_sel;
  logic [4:0] raw_shamt;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;
  logic       legal;

  // Final decoded bundle that the output register captures.
  logic [2:0]  dec_fmt;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_shamt;
  logic [4:0]  dec_alu;
  logic        dec_in1;
  logic        dec_in2;
  logic [2:0]  dec_dc_read;
  logic [1:0]  dec_dc_write;
  logic        dec_wb_sel;
  logic        dec_rd_we;
  logic        dec_illegal;

  logic hazard;

  // The fun3 field selects the same ALU operation for OP and OP-IMM; the
  // bit-30 variants (SUB, SRA) are layered on by the caller.
  function automatic logic [4:0] alu_from_fun3(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Opcode decode. FENCE and SYSTEM are legal but do nothing in this
  // pipeline, so they leave every control field at its idle value.
  always_comb begin
    raw_fmt      = FMT_R;
    raw_alu      = ALU_NONE;
    raw_in1      = 1'b0;
    raw_in2      = 1'b0;
    raw_dc_read  = 3'd0;
    raw_dc_write = 2'd0;
    raw_wb_sel   = 1'b0;
    raw_shamt    = 5'd0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    legal        = 1'b1;
    case (opcode)
      OPC_LUI: begin
        raw_fmt = FMT_U;
        raw_alu = ALU_PASS_B;
        raw_in2 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_AUIPC: begin
        raw_fmt = FMT_U;
        raw_alu = ALU_ADD;
        raw_in1 = 1'b1;
        raw_in2 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_JAL: begin
        raw_fmt = FMT_UJ;
        raw_alu = ALU_PC_PLUS4;
        raw_in1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_JALR: begin
        raw_fmt = FMT_I;
        raw_alu = ALU_PC_PLUS4;
        raw_in1 = 1'b1;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        legal   = (fun3 == 3'b000);
      end
      OPC_BRANCH: begin
        raw_fmt = FMT_SB;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (fun3[2:1])
          2'b00:   raw_alu = ALU_SUB;
          2'b10:   raw_alu = ALU_SLT;
          2'b11:   raw_alu = ALU_SLTU;
          default: legal   = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        raw_fmt    = FMT_I;
        raw_alu    = ALU_ADD;
        raw_in2    = 1'b1;
        raw_wb_sel = 1'b1;
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        case (fun3)
          3'b000:  raw_dc_read = 3'd1;
          3'b001:  raw_dc_read = 3'd2;
          3'b010:  raw_dc_read = 3'd3;
          3'b100:  raw_dc_read = 3'd4;
          3'b101:  raw_dc_read = 3'd5;
          default: legal       = 1'b0;
        endcase
      end
      OPC_STORE: begin
        raw_fmt = FMT_S;
        raw_alu = ALU_ADD;
        raw_in2 = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (fun3)
          3'b000:  raw_dc_write = 2'd1;
          3'b001:  raw_dc_write = 2'd2;
          3'b010:  raw_dc_write = 2'd3;
          default: legal        = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        raw_fmt = FMT_I;
        raw_alu = alu_from_fun3(fun3);
        raw_in2 = 1'b1;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        // Only the shift-immediates reuse the top bits as fun7; for the
        // others they are ordinary immediate bits.
        if (fun3 == 3'b001) begin
          raw_shamt = INSTRUCTION[24:20];
          legal     = (fun7 == 7'h00);
        end else if (fun3 == 3'b101) begin
          raw_shamt = INSTRUCTION[24:20];
          legal     = (fun7 == 7'h00) || (fun7 == 7'h20);
          if (INSTRUCTION[30]) begin
            raw_alu = ALU_SRA;
          end
        end
      end
      OPC_OP: begin
        raw_fmt = FMT_R;
        raw_alu = alu_from_fun3(fun3);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (fun7 == 7'h20) begin
          if (fun3 == 3'b000) begin
            raw_alu = ALU_SUB;
          end else if (fun3 == 3'b101) begin
            raw_alu = ALU_SRA;
          end else begin
            legal = 1'b0;
          end
        end else if (fun7 != 7'h00) begin
          legal = 1'b0;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        raw_fmt = FMT_I;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Zero the register fields a format does not carry, and collapse an
  // illegal encoding to an otherwise-empty bundle flagged as illegal, so
  // nothing downstream can act on it.
  always_comb begin
    dec_fmt      = 3'd0;
    dec_rs1      = 5'd0;
    dec_rs2      = 5'd0;
    dec_rd       = 5'd0;
    dec_shamt    = 5'd0;
    dec_alu      = ALU_NONE;
    dec_in1      = 1'b0;
    dec_in2      = 1'b0;
    dec_dc_read  = 3'd0;
    dec_dc_write = 2'd0;
    dec_wb_sel   = 1'b0;
    dec_rd_we    = 1'b0;
    dec_illegal  = 1'b1;
    if (legal) begin
      dec_fmt      = raw_fmt;
      dec_rs1      = use_rs1 ? INSTRUCTION[19:15] : 5'd0;
      dec_rs2      = use_rs2 ? INSTRUCTION[24:20] : 5'd0;
      dec_rd       = use_rd  ? INSTRUCTION[11:7]  : 5'd0;
      dec_shamt    = raw_shamt;
      dec_alu      = raw_alu;
      dec_in1      = raw_in1;
      dec_in2      = raw_in2;
      dec_dc_read  = raw_dc_read;
      dec_dc_write = raw_dc_write;
      dec_wb_sel   = raw_wb_sel;
      dec_rd_we    = use_rd && (INSTRUCTION[11:7] != 5'd0);
      dec_illegal  = 1'b0;
    end
  end

`ifdef DECODE_IMM_GEN_EN
  // Immediate assembly keyed off the already-gated format, so illegal and
  // R-type bundles naturally carry 0.
  always_comb begin
    dec_imm = 32'd0;
    case (dec_fmt)
      FMT_I:   dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
      FMT_S:   dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25],
                          INSTRUCTION[11:7]};
      FMT_SB:  dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[7],
                          INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
      FMT_U:   dec_imm = {INSTRUCTION[31:12], 12'd0};
      FMT_UJ:  dec_imm = {{12{INSTRUCTION[31]}}, INSTRUCTION[19:12],
                          INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
      default: dec_imm = 32'd0;
    endcase
  end
`else
  assign dec_imm = 32'd0;
`endif

  // Load-use check. Unused source fields are already zero and a held load
  // to x0 never counts, so comparing the decoded indices against the held
  // rd is enough to tell whether the incoming instruction really reads it.
  assign hazard = OUT_VALID && (DATA_CACHE_READ != 3'd0) &&
                  (RD_ADDRESS != 5'd0) && IN_VALID &&
                  ((dec_rs1 == RD_ADDRESS) || (dec_rs2 == RD_ADDRESS));

  assign IN_READY = RESET_N && !FLUSH && (!OUT_VALID || OUT_READY) && !hazard;

  // Output register: reset clears everything, flush only drops valid, an
  // accepted instruction loads a fresh bundle, and otherwise a consumed
  // bundle (or a stalled load being taken) leaves a bubble behind.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      OUT_VALID             <= 1'b0;
      OUT_PC                <= '0;
      IMM_FORMAT            <= 3'd0;
      IMMEDIATE             <= 32'd0;
      RS1_ADDRESS           <= 5'd0;
      RS2_ADDRESS           <= 5'd0;
      RD_ADDRESS            <= 5'd0;
      SHIFT_AMOUNT          <= 5'd0;
      ALU_INSTRUCTION       <= 5'd0;
      ALU_INPUT_1_SELECT    <= 1'b0;
      ALU_INPUT_2_SELECT    <= 1'b0;
      DATA_CACHE_READ       <= 3'd0;
      DATA_CACHE_WRITE      <= 2'd0;
      WRITE_BACK_MUX_SELECT <= 1'b0;
      RD_WRITE_ENABLE       <= 1'b0;
      ILLEGAL_INSTRUCTION   <= 1'b0;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
    end else if (IN_VALID && IN_READY) begin
      OUT_VALID             <= 1'b1;
      OUT_PC                <= PC;
      IMM_FORMAT            <= dec_fmt;
      IMMEDIATE             <= dec_imm;
      RS1_ADDRESS           <= dec_rs1;
      RS2_ADDRESS           <= dec_rs2;
      RD_ADDRESS            <= dec_rd;
      SHIFT_AMOUNT          <= dec_shamt;
      ALU_INSTRUCTION       <= dec_alu;
      ALU_INPUT_1_SELECT    <= dec_in1;
      ALU_INPUT_2_SELECT    <= dec_in2;
      DATA_CACHE_READ       <= dec_dc_read;
      DATA_CACHE_WRITE      <= dec_dc_write;
      WRITE_BACK_MUX_SELECT <= dec_wb_sel;
      RD_WRITE_ENABLE       <= dec_rd_we;
      ILLEGAL_INSTRUCTION   <= dec_illegal;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ins_decode_stage.sv
// tb_ins_decode_stage
//
// Self-checking bench for ins_decode_stage: directed scenarios followed by a
// randomized run checked against an instruction-level reference model.
// Honours DECODE_IMM_GEN_EN the same way the design does.

module tb_ins_decode_stage;

  logic        CLK;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        IN_READY;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        OUT_VALID;
  logic        out_ready;
  logic [31:0] OUT_PC;
  logic [2:0]  IMM_FORMAT;
  logic [31:0] IMMEDIATE;
  logic [4:0]  RS1_ADDRESS;
  logic [4:0]  RS2_ADDRESS;
  logic [4:0]  RD_ADDRESS;
  logic [4:0]  SHIFT_AMOUNT;
  logic [4:0]  ALU_INSTRUCTION;
  logic        ALU_INPUT_1_SELECT;
  logic        ALU_INPUT_2_SELECT;
  logic [2:0]  DATA_CACHE_READ;
  logic [1:0]  DATA_CACHE_WRITE;
  logic        WRITE_BACK_MUX_SELECT;
  logic        RD_WRITE_ENABLE;
  logic        ILLEGAL_INSTRUCTION;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [4:0]  alu;
    logic        in1;
    logic        in2;
    logic [2:0]  dcr;
    logic [1:0]  dcw;
    logic        wb;
    logic        we;
    logic        ill;
  } bundle_t;

  ins_decode_stage #(.ADDRESS_WIDTH(32)) dut (
    .CLK                   (CLK),
    .RESET_N               (reset_n),
    .FLUSH                 (flush),
    .IN_VALID              (in_valid),
    .IN_READY              (IN_READY),
    .INSTRUCTION           (instruction),
    .PC                    (pc),
    .OUT_VALID             (OUT_VALID),
    .OUT_READY             (out_ready),
    .OUT_PC                (OUT_PC),
    .IMM_FORMAT            (IMM_FORMAT),
    .IMMEDIATE             (IMMEDIATE),
    .RS1_ADDRESS           (RS1_ADDRESS),
    .RS2_ADDRESS           (RS2_ADDRESS),
    .RD_ADDRESS            (RD_ADDRESS),
    .SHIFT_AMOUNT          (SHIFT_AMOUNT),
    .ALU_INSTRUCTION       (ALU_INSTRUCTION),
    .ALU_INPUT_1_SELECT    (ALU_INPUT_1_SELECT),
    .ALU_INPUT_2_SELECT    (ALU_INPUT_2_SELECT),
    .DATA_CACHE_READ       (DATA_CACHE_READ),
    .DATA_CACHE_WRITE      (DATA_CACHE_WRITE),
    .WRITE_BACK_MUX_SELECT (WRITE_BACK_MUX_SELECT),
    .RD_WRITE_ENABLE       (RD_WRITE_ENABLE),
    .ILLEGAL_INSTRUCTION   (ILLEGAL_INSTRUCTION)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bundle_t sample();
    bundle_t b;
    b.valid = OUT_VALID;
    b.pc    = OUT_PC;
    b.fmt   = IMM_FORMAT;
    b.imm   = IMMEDIATE;
    b.rs1   = RS1_ADDRESS;
    b.rs2   = RS2_ADDRESS;
    b.rd    = RD_ADDRESS;
    b.shamt = SHIFT_AMOUNT;
    b.alu   = ALU_INSTRUCTION;
    b.in1   = ALU_INPUT_1_SELECT;
    b.in2   = ALU_INPUT_2_SELECT;
    b.dcr   = DATA_CACHE_READ;
    b.dcw   = DATA_CACHE_WRITE;
    b.wb    = WRITE_BACK_MUX_SELECT;
    b.we    = RD_WRITE_ENABLE;
    b.ill   = ILLEGAL_INSTRUCTION;
    return b;
  endfunction

  // Reference decode, table driven from the ISA rules.
  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] at_pc);
    bundle_t b;
    int alu_tab [8];
    int ld_tab [8];
    int br_tab [4];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] s;
    bit legal;
    bit r1;
    bit r2;
    bit wrd;
    alu_tab = '{1, 3, 4, 5, 6, 7, 9, 10};
    ld_tab  = '{1, 2, 3, 0, 4, 5, 0, 0};
    br_tab  = '{2, 0, 4, 5};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    s  = ins;
    b = '0;
    legal = 1'b1;
    r1 = 1'b0;
    r2 = 1'b0;
    wrd = 1'b0;
    case (op)
      7'h37: begin b.fmt = 3; b.alu = 11; b.in2 = 1; wrd = 1; b.imm = ins & 32'hFFFFF000; end
      7'h17: begin b.fmt = 3; b.alu = 1; b.in1 = 1; b.in2 = 1; wrd = 1; b.imm = ins & 32'hFFFFF000; end
      7'h6F: begin
        b.fmt = 5; b.alu = 12; b.in1 = 1; wrd = 1;
        b.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: begin b.fmt = 1; b.alu = 12; b.in1 = 1; r1 = 1; wrd = 1; b.imm = s >>> 20; legal = (f3 == 0); end
      7'h63: begin
        b.fmt = 4; r1 = 1; r2 = 1;
        b.alu = 5'(br_tab[f3[2:1]]);
        legal = (br_tab[f3[2:1]] != 0);
        b.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h03: begin
        b.fmt = 1; b.alu = 1; b.in2 = 1; b.wb = 1; r1 = 1; wrd = 1; b.imm = s >>> 20;
        b.dcr = 3'(ld_tab[f3]);
        legal = (ld_tab[f3] != 0);
      end
      7'h23: begin
        b.fmt = 2; b.alu = 1; b.in2 = 1; r1 = 1; r2 = 1;
        b.imm = ((s >>> 20) & ~32'h1F) | {27'd0, ins[11:7]};
        legal = (f3 < 3);
        b.dcw = 2'(f3 + 1);
      end
      7'h13: begin
        b.fmt = 1; b.in2 = 1; r1 = 1; wrd = 1; b.imm = s >>> 20;
        b.alu = 5'(alu_tab[f3]);
        if (f3 == 1) begin b.shamt = ins[24:20]; legal = (f7 == 0); end
        if (f3 == 5) begin
          b.shamt = ins[24:20];
          legal = (f7 == 0) || (f7 == 7'h20);
          if (ins[30]) b.alu = 8;
        end
      end
      7'h33: begin
        b.fmt = 0; r1 = 1; r2 = 1; wrd = 1;
        b.alu = 5'(alu_tab[f3]);
        if (f7 == 7'h20) begin
          if (f3 == 0) b.alu = 2;
          else if (f3 == 5) b.alu = 8;
          else legal = 0;
        end else if (f7 != 0) begin
          legal = 0;
        end
      end
      7'h0F, 7'h73: begin b.fmt = 1; b.imm = s >>> 20; end
      default: legal = 0;
    endcase
    if (r1) b.rs1 = ins[19:15];
    if (r2) b.rs2 = ins[24:20];
    if (wrd) b.rd = ins[11:7];
    b.we = wrd && (ins[11:7] != 0);
`ifndef DECODE_IMM_GEN_EN
    b.imm = '0;
`endif
    if (!legal) b = '0;
    b.ill   = !legal;
    b.valid = 1'b1;
    b.pc    = at_pc;
    return b;
  endfunction

  // Random instruction biased toward real opcodes and a small register set
  // so that load-use collisions happen often.
  function automatic logic [31:0] gen_ins();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h03;
      7: w[6:0] = 7'h23;
      8: w[6:0] = 7'h13;
      9: w[6:0] = 7'h33;
      default: ;
    endcase
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    bundle_t got;
    reset_n = 0; flush = 0; in_valid = 1; out_ready = 1;
    instruction = 32'h002081B3; pc = 32'h100;
    #1;
    total++;
    if (IN_READY !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", IN_READY); end
    step(); step();
    got = sample();
    total++;
    if (got !== '0) begin bad++; $display("[TB] FAIL reset_outputs got=%h want=0", got); end
    reset_n = 1; in_valid = 0;
    step();
  endtask

  task automatic test_add();
    bundle_t got;
    in_valid = 1; out_ready = 1; instruction = 32'h002081B3; pc = 32'h100;
    #1;
    total++;
    if (IN_READY !== 1'b1) begin bad++; $display("[TB] FAIL add_in_ready got=%b want=1", IN_READY); end
    step();
    in_valid = 0;
    got = sample();
    total++;
    if ({got.valid, got.alu, got.rs1, got.rs2, got.rd, got.we, got.pc} !==
        {1'b1, 5'd1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h100}) begin
      bad++; $display("[TB] FAIL add_fields got=%h want=valid1 alu1 rs1 rs2 rd3 we1 pc100", got);
    end
    total++;
    if (got !== model_decode(32'h002081B3, 32'h100)) begin
      bad++; $display("[TB] FAIL add_bundle got=%h want=%h", got, model_decode(32'h002081B3, 32'h100));
    end
    step();
  endtask

  task automatic test_back_to_back();
    bundle_t got;
    logic [31:0] exp_imm;
`ifdef DECODE_IMM_GEN_EN
    exp_imm = 32'hFFFFFFFF;
`else
    exp_imm = 32'h0;
`endif
    in_valid = 1; out_ready = 1; instruction = 32'h402081B3; pc = 32'h110;
    step();
    instruction = 32'hFFF00093; pc = 32'h114;
    got = sample();
    total++;
    if ({got.valid, got.alu} !== {1'b1, 5'd2}) begin
      bad++; $display("[TB] FAIL b2b_sub got=valid%b alu%0d want=valid1 alu2", got.valid, got.alu);
    end
    step();
    in_valid = 0;
    got = sample();
    total++;
    if ({got.valid, got.alu, got.in2, got.rs2, got.rd, got.imm, got.pc} !==
        {1'b1, 5'd1, 1'b1, 5'd0, 5'd1, exp_imm, 32'h114}) begin
      bad++; $display("[TB] FAIL b2b_addi got=%h want imm=%h", got, exp_imm);
    end
    step();
  endtask

  task automatic test_load_use();
    bundle_t got;
    in_valid = 1; out_ready = 1; instruction = 32'h0000A283; pc = 32'h120;
    step();
    got = sample();
    total++;
    if ({got.valid, got.dcr, got.wb, got.rd, got.we} !== {1'b1, 3'd3, 1'b1, 5'd5, 1'b1}) begin
      bad++; $display("[TB] FAIL lw_bundle got=%h want=dcr3 wb1 rd5", got);
    end
    instruction = 32'h00028333; pc = 32'h124;
    #1;
    total++;
    if (IN_READY !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall got=%b want=0", IN_READY); end
    step();
    total++;
    if (OUT_VALID !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble got=%b want=0", OUT_VALID); end
    step();
    in_valid = 0;
    got = sample();
    total++;
    if (got !== model_decode(32'h00028333, 32'h124)) begin
      bad++; $display("[TB] FAIL lu_add got=%h want=%h", got, model_decode(32'h00028333, 32'h124));
    end
    // Load to x0 must not stall a reader of x0.
    in_valid = 1; instruction = 32'h0000A003; pc = 32'h130;
    step();
    instruction = 32'h00000333; pc = 32'h134;
    #1;
    total++;
    if (IN_READY !== 1'b1) begin bad++; $display("[TB] FAIL lw_x0_nostall got=%b want=1", IN_READY); end
    step();
    in_valid = 0;
    total++;
    if ({OUT_VALID, OUT_PC, RD_ADDRESS} !== {1'b1, 32'h134, 5'd6}) begin
      bad++; $display("[TB] FAIL lw_x0_next got=v%b pc%h rd%0d want=v1 pc134 rd6", OUT_VALID, OUT_PC, RD_ADDRESS);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    bundle_t got;
    bundle_t exp;
    words = '{32'h00000000, 32'h0020A1E3};
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; instruction = words[i]; pc = 32'h140 + 32'(i * 4);
      step();
      in_valid = 0;
      got = sample();
      exp = '0;
      exp.valid = 1; exp.pc = 32'h140 + 32'(i * 4); exp.ill = 1;
      total++;
      if (got !== exp) begin bad++; $display("[TB] FAIL illegal_%0d got=%h want=%h", i, got, exp); end
    end
    step();
  endtask

  task automatic test_backpressure_flush();
    bundle_t got;
    bundle_t exp;
    in_valid = 1; out_ready = 1; instruction = 32'h00A00513; pc = 32'h200;
    step();
    exp = model_decode(32'h00A00513, 32'h200);
    instruction = 32'h00150593; pc = 32'h204; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (IN_READY !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready_%0d got=%b want=0", i, IN_READY); end
      step();
      got = sample();
      total++;
      if (got !== exp) begin bad++; $display("[TB] FAIL hold_stable_%0d got=%h want=%h", i, got, exp); end
    end
    flush = 1; out_ready = 1;
    #1;
    total++;
    if (IN_READY !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready got=%b want=0", IN_READY); end
    step();
    flush = 0; in_valid = 0;
    total++;
    if (OUT_VALID !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b want=0", OUT_VALID); end
    step();
  endtask

  task automatic test_reset_midstream();
    bundle_t got;
    in_valid = 1; out_ready = 0; instruction = 32'h00A00513; pc = 32'h300;
    step();
    in_valid = 0; reset_n = 0;
    step();
    got = sample();
    total++;
    if ({got, IN_READY} !== '0) begin bad++; $display("[TB] FAIL midreset got=%h rdy=%b want=0", got, IN_READY); end
    reset_n = 1; out_ready = 1; in_valid = 1; instruction = 32'h002081B3; pc = 32'h104;
    step();
    in_valid = 0;
    got = sample();
    total++;
    if (got !== model_decode(32'h002081B3, 32'h104)) begin
      bad++; $display("[TB] FAIL after_reset got=%h want=%h", got, model_decode(32'h002081B3, 32'h104));
    end
    step();
  endtask

  task automatic test_random();
    bundle_t m;
    bundle_t got;
    bundle_t exp_dec;
    bit haz;
    bit exp_ready;
    m = '0;
    m.valid = OUT_VALID;
    for (int c = 0; c < 800; c++) begin
      got = sample();
      total++;
      if (m.valid) begin
        if (got !== m) begin bad++; $display("[TB] FAIL rand_bundle_%0d got=%h want=%h", c, got, m); end
      end else if (got.valid !== 1'b0) begin
        bad++; $display("[TB] FAIL rand_valid_%0d got=%b want=0", c, got.valid);
      end
      reset_n     = ($urandom_range(0, 99) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      instruction = gen_ins();
      pc          = $urandom & 32'hFFFFFFFC;
      #1;
      exp_dec = model_decode(instruction, pc);
      haz = m.valid && (m.dcr != 0) && (m.rd != 0) && in_valid &&
            ((exp_dec.rs1 == m.rd) || (exp_dec.rs2 == m.rd));
      exp_ready = reset_n && !flush && (!m.valid || out_ready) && !haz;
      total++;
      if (IN_READY !== exp_ready) begin
        bad++; $display("[TB] FAIL rand_ready_%0d got=%b want=%b", c, IN_READY, exp_ready);
      end
      @(posedge CLK);
      if (!reset_n) m = '0;
      else if (flush) m.valid = 1'b0;
      else if (in_valid && exp_ready) m = exp_dec;
      else if (out_ready) m.valid = 1'b0;
      @(negedge CLK);
    end
    reset_n = 1; flush = 0; in_valid = 0; out_ready = 1;
    step();
  endtask

  initial begin
    reset_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    instruction = '0; pc = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_illegal();
    test_backpressure_flush();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
